dpram_fifo_ctrl: RTL and testbench
==================================

Name: dpram_fifo_ctrl

Overview:
Synchronous FIFO controller that drives an external inferred dual-port RAM (32x4 by default).
- Port A is used write-only: ena, wea, addra, dia.
- Port B is used read-only: enb, addrb, dob.
- Supplies the write/read pointer logic, occupancy tracking and flags the bare RAM lacks, so producers and consumers share the RAM as a queue.

Parameters:
DATA_W, 4, data width; must match the RAM word width.
ADDR_W, 5, RAM address width; FIFO depth = 2**ADDR_W.
ALMOST_FULL_TH, 28, count at or above which almost_full asserts (optional feature only).
ALMOST_EMPTY_TH, 4, count at or below which almost_empty asserts (optional feature only).

Ports:
clk  in  1  single clock for the controller and the RAM.
rst  in  1  synchronous, active-high reset.
wr_en  in  1  write request.
wr_data  in  DATA_W  write data.
full  out  1  FIFO holds 2**ADDR_W entries.
rd_en  in  1  read request.
rd_data  out  DATA_W  read data; valid when rd_valid=1.
rd_valid  out  1  rd_data valid this cycle.
empty  out  1  FIFO holds 0 entries.
count  out  ADDR_W+1  current occupancy.
overflow  out  1  sticky: write attempted while full.
underflow  out  1  sticky: read attempted while empty.
ram_ena  out  1  RAM port A enable.
ram_wea  out  1  RAM port A write enable.
ram_addra  out  ADDR_W  RAM port A address.
ram_dia  out  DATA_W  RAM port A write data.
ram_enb  out  1  RAM port B enable.
ram_addrb  out  ADDR_W  RAM port B address.
ram_dob  in  DATA_W  RAM port B read data; registered, 1-cycle latency.

Behaviour:
- Clocking and reset: one clock (clk). Reset rst is synchronous, active-high.
- Values while rst=1 and on the first cycle after reset:
  - wr_ptr=0, rd_ptr=0, count=0.
  - empty=1, full=0, rd_valid=0, overflow=0, underflow=0.
  - All ram_* enables are 0.
- Write accept: wr_acc = wr_en & ~full.
  - Combinational outputs: ram_ena = ram_wea = wr_acc; ram_addra = wr_ptr; ram_dia = wr_data.
  - wr_ptr increments on the next edge and wraps from 2**ADDR_W-1 to 0.
- Read accept: rd_acc = rd_en & ~empty.
  - Combinational outputs: ram_enb = rd_acc; ram_addrb = rd_ptr.
  - rd_ptr increments and wraps like wr_ptr.
  - rd_valid is registered rd_acc: it asserts exactly 1 cycle after acceptance.
  - rd_data = ram_dob (pass-through) whenever rd_valid=1; otherwise rd_data holds its last value.
- Read-to-data latency is exactly 1 cycle. Back-to-back reads give one word per cycle.
- Occupancy update, count' = count + wr_acc - rd_acc:
  - Simultaneous accepted read and write leaves count unchanged.
  - full = (count == 2**ADDR_W); empty = (count == 0). Both are registered and derived from count.
- Flag sampling: flags are sampled before the current cycle's accepts.
  - Write while full: dropped and sets overflow, even if a read is accepted the same cycle.
  - Read while empty: dropped, no rd_valid, sets underflow, even if a write is accepted the same cycle.
- No same-address collision: port A never writes the address port B reads in the same cycle (reads blocked when empty, writes blocked when full). No bypass path is needed.
- overflow and underflow clear only on rst.
- Reset mid-operation: an outstanding read response is discarded (rd_valid=0 on the next cycle) and RAM contents are not cleared. Stale data is never visible, because empty=1.

Optional Feature:
Macro: DPRAM_FIFO_ALMOST_EN.
- Defined: adds outputs almost_full and almost_empty (1 bit each), registered alongside count.
  - almost_full = (count' >= ALMOST_FULL_TH).
  - almost_empty = (count' <= ALMOST_EMPTY_TH).
  - Reset values: almost_full=0, almost_empty=1.
- Undefined: both ports, the thresholds' logic and their registers are absent. The parameters remain but are unused.

Decomposition:
- Shared package dpram_fifo_pkg holds:
  - defaults DATA_W=4 and ADDR_W=5;
  - localparam DEPTH = 2**ADDR_W;
  - the width of count (ADDR_W+1).
- One natural sub-module: fifo_ptr, a wrapping ADDR_W-bit pointer with increment enable and sync reset, instantiated twice (wr/rd).
- Occupancy and flag logic stays in the top level.

Test Plan:
- Write 4'hA then 4'hC from reset, then read twice -> ram_addra 0 then 1; rd_valid on the 2 cycles after the read requests; rd_data A then C; count 0,1,2,1,0; empty=1 at end.
- Write 32 words 0..F,0..F -> full=1 at count=32; 33rd wr_en leaves ram_ena=0 and sets overflow=1; 32 reads return the same sequence and ptrs wrap to 0.
- rd_en from reset -> ram_enb=0, rd_valid stays 0, underflow=1, count=0.
- At count=5, wr_en and rd_en held together for 10 cycles -> count stays 5 and data order is preserved; at full, simultaneous wr+rd -> read accepted, write dropped, count=31.
- rst asserted the cycle after a read is accepted -> rd_valid=0 next cycle; count=0, empty=1; a subsequent write/read of 4'h7 returns 7.
- With DPRAM_FIFO_ALMOST_EN defined, fill to 28 -> almost_full rises on the 28th write's edge; drain to 4 -> almost_empty=1.

Source files
------------

// File: rtl/dpram_fifo_pkg.sv
// Shared defaults and width helpers for the dual-port-RAM FIFO controller.
package dpram_fifo_pkg;

  localparam int DATA_W_DEF = 4;
  localparam int ADDR_W_DEF = 5;
  localparam int DEPTH      = 2 ** ADDR_W_DEF;
  localparam int CNT_W      = ADDR_W_DEF + 1;

  // Occupancy needs one extra bit so that a completely full FIFO is representable.
  function automatic int cnt_width(input int addr_w);
    return addr_w + 1;
  endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Wrapping ADDR_W-bit FIFO pointer with increment enable and synchronous reset.
module fifo_ptr
  import dpram_fifo_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  output logic [ADDR_W-1:0] ptr
);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst)      ptr <= '0;
    else if (inc) ptr <= ptr + 1'b1;
  end

endmodule

// File: rtl/dpram_fifo_ctrl.sv
// FIFO controller wrapping an external dual-port RAM (port A write, port B read).
// Optional almost_full/almost_empty outputs are enabled by defining DPRAM_FIFO_ALMOST_EN.
module dpram_fifo_ctrl
  import dpram_fifo_pkg::*;
#(
  parameter int DATA_W          = DATA_W_DEF,
  parameter int ADDR_W          = ADDR_W_DEF,
  parameter int ALMOST_FULL_TH  = 28,
  parameter int ALMOST_EMPTY_TH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr_en,
  input  logic [DATA_W-1:0]           wr_data,
  output logic                        full,
  input  logic                        rd_en,
  output logic [DATA_W-1:0]           rd_data,
  output logic                        rd_valid,
  output logic                        empty,
  output logic [cnt_width(ADDR_W)-1:0] count,
  output logic                        overflow,
  output logic                        underflow,
`ifdef DPRAM_FIFO_ALMOST_EN
  output logic                        almost_full,
  output logic                        almost_empty,
`endif
  output logic                        ram_ena,
  output logic                        ram_wea,
  output logic [ADDR_W-1:0]           ram_addra,
  output logic [DATA_W-1:0]           ram_dia,
  output logic                        ram_enb,
  output logic [ADDR_W-1:0]           ram_addrb,
  input  logic [DATA_W-1:0]           ram_dob
);

  localparam int              CW        = cnt_width(ADDR_W);
  localparam logic [CW-1:0]   DEPTH_CNT = CW'(2 ** ADDR_W);

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              wr_acc;
  logic              rd_acc;
  logic [CW-1:0]     count_next;
  logic [DATA_W-1:0] rd_data_q;

  // Accepts use the registered flags, so a full/empty decision never depends on this cycle's traffic.
  assign wr_acc    = wr_en & ~full & ~rst;
  assign rd_acc    = rd_en & ~empty & ~rst;

  assign ram_ena   = wr_acc;
  assign ram_wea   = wr_acc;
  assign ram_addra = wr_ptr;
  assign ram_dia   = wr_data;
  assign ram_enb   = rd_acc;
  assign ram_addrb = rd_ptr;

  assign rd_data   = rd_valid ? ram_dob : rd_data_q;

  fifo_ptr #(.ADDR_W(ADDR_W)) u_wr_ptr (.clk(clk), .rst(rst), .inc(wr_acc), .ptr(wr_ptr));
  fifo_ptr #(.ADDR_W(ADDR_W)) u_rd_ptr (.clk(clk), .rst(rst), .inc(rd_acc), .ptr(rd_ptr));

  // NOTE: the default assignment first keeps this block free of inferred latches.
  always_comb begin
    count_next = count;
    case ({wr_acc, rd_acc})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count     <= '0;
      empty     <= 1'b1;
      full      <= 1'b0;
      rd_valid  <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      rd_data_q <= '0;
    end else begin
      count    <= count_next;
      empty    <= (count_next == '0);
      full     <= (count_next == DEPTH_CNT);
      rd_valid <= rd_acc;
      if (wr_en && full)  overflow  <= 1'b1;
      if (rd_en && empty) underflow <= 1'b1;
      if (rd_valid)       rd_data_q <= ram_dob;
    end
  end

`ifdef DPRAM_FIFO_ALMOST_EN
  localparam logic [CW-1:0] AF_TH = CW'(ALMOST_FULL_TH);
  localparam logic [CW-1:0] AE_TH = CW'(ALMOST_EMPTY_TH);

  always_ff @(posedge clk) begin
    if (rst) begin
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      almost_full  <= (count_next >= AF_TH);
      almost_empty <= (count_next <= AE_TH);
    end
  end
`endif

endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// Self-checking bench for dpram_fifo_ctrl: behavioural RAM, queue model and read-data scoreboard.
module tb_dpram_fifo_ctrl;
  import dpram_fifo_pkg::*;

  localparam int DW = DATA_W_DEF;
  localparam int AW = ADDR_W_DEF;

  logic          clk = 1'b0;
  logic          rst, wr_en, rd_en;
  logic [DW-1:0] wr_data, rd_data, ram_dia, ram_dob;
  logic          full, empty, rd_valid, overflow, underflow;
  logic [CNT_W-1:0] count;
  logic          ram_ena, ram_wea, ram_enb;
  logic [AW-1:0] ram_addra, ram_addrb;
`ifdef DPRAM_FIFO_ALMOST_EN
  logic          almost_full, almost_empty;
`endif

  always #5 clk = ~clk;

  dpram_fifo_ctrl dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .full(full),
    .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid), .empty(empty),
    .count(count), .overflow(overflow), .underflow(underflow),
`ifdef DPRAM_FIFO_ALMOST_EN
    .almost_full(almost_full), .almost_empty(almost_empty),
`endif
    .ram_ena(ram_ena), .ram_wea(ram_wea), .ram_addra(ram_addra), .ram_dia(ram_dia),
    .ram_enb(ram_enb), .ram_addrb(ram_addrb), .ram_dob(ram_dob)
  );

  // Behavioural dual-port RAM with registered port-B read.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (ram_ena && ram_wea) mem[ram_addra] <= ram_dia;
    if (ram_enb)            ram_dob <= mem[ram_addrb];
  end

  // Reference model state.
  logic [DW-1:0] m_q [$];
  logic [DW-1:0] sb  [$];
  logic [AW-1:0] m_wp, m_rp;
  bit            m_ovf, m_unf, exp_rv, have_last;
  logic [DW-1:0] last;

  // Combinational outputs captured before the edge.
  logic          c_ena, c_enb;
  logic [AW-1:0] c_addra, c_addrb;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive, check combinational RAM controls, advance model, check registered outputs.
  task automatic step(input bit r, input bit w, input logic [DW-1:0] d, input bit rd);
    bit            wa, ra;
    logic [DW-1:0] v;
    rst = r; wr_en = w; wr_data = d; rd_en = rd;
    wa = w && !r && (m_q.size() < DEPTH);
    ra = rd && !r && (m_q.size() > 0);
    #1;
    c_ena = ram_ena; c_enb = ram_enb; c_addra = ram_addra; c_addrb = ram_addrb;
    check("ram_ena", ram_ena, wa);
    check("ram_wea", ram_wea, wa);
    check("ram_enb", ram_enb, ra);
    if (wa) begin
      check("ram_addra", ram_addra, m_wp);
      check("ram_dia", ram_dia, d);
    end
    if (ra) check("ram_addrb", ram_addrb, m_rp);

    if (r) begin
      m_q.delete(); sb.delete();
      m_wp = '0; m_rp = '0; m_ovf = 0; m_unf = 0; exp_rv = 0; have_last = 0;
    end else begin
      if (w && m_q.size() == DEPTH) m_ovf = 1;
      if (rd && m_q.size() == 0)    m_unf = 1;
      if (ra) begin v = m_q.pop_front(); sb.push_back(v); m_rp++; end
      if (wa) begin m_q.push_back(d); m_wp++; end
      exp_rv = ra;
    end

    @(posedge clk); #1;
    check("count", count, m_q.size());
    check("empty", empty, m_q.size() == 0);
    check("full", full, m_q.size() == DEPTH);
    check("rd_valid", rd_valid, exp_rv);
    check("overflow", overflow, m_ovf);
    check("underflow", underflow, m_unf);
    if (exp_rv) begin
      if (sb.size() == 0) begin
        check("scoreboard_empty", 1, 0);
      end else begin
        v = sb.pop_front();
        check("rd_data", rd_data, v);
        last = v; have_last = 1;
      end
    end else if (have_last) begin
      check("rd_data_hold", rd_data, last);
    end
`ifdef DPRAM_FIFO_ALMOST_EN
    check("almost_full", almost_full, m_q.size() >= 28);
    check("almost_empty", almost_empty, m_q.size() <= 4);
`endif
  endtask

  typedef struct {
    bit            wr;
    logic [DW-1:0] d;
    bit            rd;
    bit            ena;
    bit            enb;
    logic [AW-1:0] addr;
    int            cnt;
    bit            emp;
    bit            rv;
    logic [DW-1:0] rdat;
  } vec_t;

  vec_t tbl [5];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tbl[0] = '{1, 4'hA, 0, 1, 0, 5'd0, 1, 0, 0, 4'h0};
    tbl[1] = '{1, 4'hC, 0, 1, 0, 5'd1, 2, 0, 0, 4'h0};
    tbl[2] = '{0, 4'h0, 1, 0, 1, 5'd0, 1, 0, 1, 4'hA};
    tbl[3] = '{0, 4'h0, 1, 0, 1, 5'd1, 0, 1, 1, 4'hC};
    tbl[4] = '{0, 4'h0, 0, 0, 0, 5'd0, 0, 1, 0, 4'h0};

    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;

    // Reset with both requests high: RAM enables must stay low.
    step(1, 1, 4'h3, 1);
    step(1, 0, 4'h0, 0);

    // Basic write/write/read/read from the table.
    foreach (tbl[i]) begin
      step(0, tbl[i].wr, tbl[i].d, tbl[i].rd);
      check("tbl_ena", c_ena, tbl[i].ena);
      check("tbl_enb", c_enb, tbl[i].enb);
      if (tbl[i].ena) check("tbl_addra", c_addra, tbl[i].addr);
      if (tbl[i].enb) check("tbl_addrb", c_addrb, tbl[i].addr);
      check("tbl_count", count, tbl[i].cnt);
      check("tbl_empty", empty, tbl[i].emp);
      check("tbl_rd_valid", rd_valid, tbl[i].rv);
      if (tbl[i].rv) check("tbl_rd_data", rd_data, tbl[i].rdat);
    end

    // Read from empty after reset.
    step(1, 0, 4'h0, 0);
    step(0, 0, 4'h0, 1);
    check("unf_enb", c_enb, 0);
    check("unf_flag", underflow, 1);
    check("unf_count", count, 0);
    check("unf_rd_valid", rd_valid, 0);
    step(0, 1, 4'h2, 1);
    step(0, 0, 4'h0, 1);

    // Fill to full, overflow, drain with wrap.
    step(1, 0, 4'h0, 0);
    for (int i = 0; i < 32; i++) step(0, 1, 4'(i), 0);
    check("fill_full", full, 1);
    check("fill_count", count, 32);
    step(0, 1, 4'h5, 0);
    check("ovf_ena", c_ena, 0);
    check("ovf_flag", overflow, 1);
    for (int i = 0; i < 32; i++) step(0, 0, 4'h0, 1);
    check("drain_empty", empty, 1);
    step(0, 1, 4'h9, 0);
    check("wrap_addra", c_addra, 0);
    step(0, 0, 4'h0, 1);
    check("wrap_addrb", c_addrb, 0);
    step(0, 0, 4'h0, 0);

    // Simultaneous traffic at count 5, then at full.
    step(1, 0, 4'h0, 0);
    for (int i = 0; i < 5; i++)  step(0, 1, 4'(i + 1), 0);
    for (int i = 0; i < 10; i++) step(0, 1, 4'(i + 8), 1);
    check("simul_count", count, 5);
    for (int i = 0; i < 27; i++) step(0, 1, 4'(i), 0);
    check("simul_full", full, 1);
    step(0, 1, 4'hF, 1);
    check("full_rw_enb", c_enb, 1);
    check("full_rw_ena", c_ena, 0);
    check("full_rw_count", count, 31);
    check("full_rw_ovf", overflow, 1);

    // Reset the cycle after a read is accepted.
    step(1, 0, 4'h0, 0);
    for (int i = 1; i <= 3; i++) step(0, 1, 4'(i), 0);
    step(0, 0, 4'h0, 1);
    step(1, 0, 4'h0, 0);
    check("rst_mid_rd_valid", rd_valid, 0);
    check("rst_mid_count", count, 0);
    check("rst_mid_empty", empty, 1);
    step(0, 1, 4'h7, 0);
    step(0, 0, 4'h0, 1);
    check("rst_mid_rd_data", rd_data, 4'h7);
    step(0, 0, 4'h0, 0);

`ifdef DPRAM_FIFO_ALMOST_EN
    // Almost-full / almost-empty thresholds.
    step(1, 0, 4'h0, 0);
    for (int i = 0; i < 27; i++) step(0, 1, 4'(i), 0);
    check("af_below", almost_full, 0);
    step(0, 1, 4'hE, 0);
    check("af_at_th", almost_full, 1);
    for (int i = 0; i < 23; i++) step(0, 0, 4'h0, 1);
    check("ae_above", almost_empty, 0);
    step(0, 0, 4'h0, 1);
    check("ae_at_th", almost_empty, 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
